// File: rtl/colour_bbox_pkg.sv
// Shared types for the colour bounding-box tracker.
// Result fields are sized for the largest supported frame.
package colour_bbox_pkg;

    localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;
    localparam int BB_COORD_W = 16;
    localparam int BB_CNT_W   = 32;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic [BB_COORD_W-1:0] xmin;
        logic [BB_COORD_W-1:0] xmax;
        logic [BB_COORD_W-1:0] ymin;
        logic [BB_COORD_W-1:0] ymax;
        logic [BB_CNT_W-1:0]   count;
        logic                  found;
        logic                  size_err;
    } bbox_t;

    typedef enum logic [1:0] {
        IDLE,
        VIDEO,
        SKIP
    } state_e;

    function automatic logic in_range(input logic [7:0] v,
                                      input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/colour_bbox_tracker_match.sv
// Registered inclusive RGB window compare; coordinates and
// frame tags ride alongside with the same one-cycle latency.
module colour_window_match
    import colour_bbox_pkg::*;
#(
    parameter int COORD_W = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vld_i,
    input  logic [23:0]        pix_i,
    input  logic [23:0]        lo_i,
    input  logic [23:0]        hi_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [2:0]         tag_i,
    output logic               vld_o,
    output logic               match_o,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic [2:0]         tag_o
);

    rgb_t p;
    rgb_t l;
    rgb_t h;
    logic hit;

    assign p = pix_i;
    assign l = lo_i;
    assign h = hi_i;
    assign hit = in_range(p.r, l.r, h.r)
              && in_range(p.g, l.g, h.g)
              && in_range(p.b, l.b, h.b);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_o   <= 1'b0;
            match_o <= 1'b0;
            x_o     <= '0;
            y_o     <= '0;
            tag_o   <= '0;
        end else begin
            vld_o <= vld_i;
            if (vld_i) begin
                match_o <= hit;
                x_o     <= x_i;
                y_o     <= y_i;
                tag_o   <= tag_i;
            end
        end
    end

endmodule

// File: rtl/colour_bbox_tracker.sv
// Avalon-ST video passthrough that reports, per frame, the bounding
// box and count of pixels falling inside a programmable RGB window.
module colour_bbox_tracker
    import colour_bbox_pkg::*;
#(
    parameter int IMAGE_W = 640,
    parameter int IMAGE_H = 480,
    parameter int COORD_W = 11,
    parameter int CNT_W   = 19
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [23:0]        snk_data,
    input  logic               snk_valid,
    input  logic               snk_startofpacket,
    input  logic               snk_endofpacket,
    output logic               snk_ready,
    output logic [23:0]        src_data,
    output logic               src_valid,
    output logic               src_startofpacket,
    output logic               src_endofpacket,
    input  logic               src_ready,
    input  logic [23:0]        thr_lo,
    input  logic [23:0]        thr_hi,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [COORD_W-1:0] res_xmin,
    output logic [COORD_W-1:0] res_xmax,
    output logic [COORD_W-1:0] res_ymin,
    output logic [COORD_W-1:0] res_ymax,
    output logic [CNT_W-1:0]   res_count,
    output logic               res_found,
    output logic               res_size_err,
    output logic               res_overflow
);

    localparam int BEAT_W = CNT_W + 1;
    localparam logic [BEAT_W-1:0] FRAME_PIX = BEAT_W'(IMAGE_W * IMAGE_H);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMAGE_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMAGE_H - 1);
    localparam int T_PIX   = 2;
    localparam int T_FIRST = 1;
    localparam int T_LAST  = 0;

    assign src_data          = snk_data;
    assign src_valid         = snk_valid;
    assign src_startofpacket = snk_startofpacket;
    assign src_endofpacket   = snk_endofpacket;
    assign snk_ready         = src_ready;

    logic beat;
    assign beat = snk_valid && src_ready;

    state_e             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               first_q, first_d;
    logic [23:0]        lo_q, lo_d, hi_q, hi_d;
    logic               s0_vld;
    logic [2:0]         s0_tag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            first_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            first_q <= first_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    // A header-only video packet emits a pixel-less first+last token
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        first_d = first_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        s0_vld  = 1'b0;
        s0_tag  = 3'b000;
        if (beat) begin
            if (snk_startofpacket) begin
                lo_d    = thr_lo;
                hi_d    = thr_hi;
                x_d     = '0;
                y_d     = '0;
                first_d = 1'b1;
                if (snk_data[3:0] == PKT_TYPE_VIDEO) begin
                    if (snk_endofpacket) begin
                        state_d = IDLE;
                        s0_vld  = 1'b1;
                        s0_tag  = 3'b011;
                    end else begin
                        state_d = VIDEO;
                    end
                end else begin
                    state_d = snk_endofpacket ? IDLE : SKIP;
                end
            end else begin
                case (state_q)
                    VIDEO: begin
                        s0_vld  = 1'b1;
                        s0_tag  = {1'b1, first_q, snk_endofpacket};
                        first_d = 1'b0;
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            if (y_q != Y_LAST) y_d = y_q + 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                        if (snk_endofpacket) state_d = IDLE;
                    end
                    SKIP: begin
                        if (snk_endofpacket) state_d = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    logic               s1_vld;
    logic               s1_match;
    logic [COORD_W-1:0] s1_x, s1_y;
    logic [2:0]         s1_tag;

    colour_window_match #(.COORD_W(COORD_W)) u_match (
        .clk     (clk),
        .reset   (reset),
        .vld_i   (s0_vld),
        .pix_i   (snk_data),
        .lo_i    (lo_q),
        .hi_i    (hi_q),
        .x_i     (x_q),
        .y_i     (y_q),
        .tag_i   (s0_tag),
        .vld_o   (s1_vld),
        .match_o (s1_match),
        .x_o     (s1_x),
        .y_o     (s1_y),
        .tag_o   (s1_tag)
    );

    logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic [COORD_W-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BEAT_W-1:0]  beats_q, beats_d;
    logic               fin_q, fin_d;
    logic [COORD_W-1:0] bxmin, bxmax, bymin, bymax;
    logic [CNT_W-1:0]   bcnt;
    logic [BEAT_W-1:0]  bbeats;

    // Accumulators restart on the first pixel token, not at the header,
    // so the previous frame's in-flight pixels still land in its totals.
    always_comb begin
        bxmin   = s1_tag[T_FIRST] ? '1 : xmin_q;
        bxmax   = s1_tag[T_FIRST] ? '0 : xmax_q;
        bymin   = s1_tag[T_FIRST] ? '1 : ymin_q;
        bymax   = s1_tag[T_FIRST] ? '0 : ymax_q;
        bcnt    = s1_tag[T_FIRST] ? '0 : cnt_q;
        bbeats  = s1_tag[T_FIRST] ? '0 : beats_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        cnt_d   = cnt_q;
        beats_d = beats_q;
        fin_d   = 1'b0;
        if (s1_vld) begin
            xmin_d  = bxmin;
            xmax_d  = bxmax;
            ymin_d  = bymin;
            ymax_d  = bymax;
            cnt_d   = bcnt;
            beats_d = bbeats;
            fin_d   = s1_tag[T_LAST];
            if (s1_tag[T_PIX]) begin
                if (bbeats != '1) beats_d = bbeats + 1'b1;
                if (s1_match) begin
                    if (s1_x < bxmin) xmin_d = s1_x;
                    if (s1_x > bxmax) xmax_d = s1_x;
                    if (s1_y < bymin) ymin_d = s1_y;
                    if (s1_y > bymax) ymax_d = s1_y;
                    if (bcnt != '1) cnt_d = bcnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xmin_q  <= '1;
            xmax_q  <= '0;
            ymin_q  <= '1;
            ymax_q  <= '0;
            cnt_q   <= '0;
            beats_q <= '0;
            fin_q   <= 1'b0;
        end else begin
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            cnt_q   <= cnt_d;
            beats_q <= beats_d;
            fin_q   <= fin_d;
        end
    end

    bbox_t res_q, res_d, res_new;
    logic  rv_q, rv_d, ovf_q, ovf_d;
    logic  xfer;
    logic  found;

    assign xfer  = rv_q && res_ready;
    assign found = (cnt_q != '0);

    always_comb begin
        res_new.xmin     = found ? BB_COORD_W'(xmin_q) : '0;
        res_new.xmax     = found ? BB_COORD_W'(xmax_q) : '0;
        res_new.ymin     = found ? BB_COORD_W'(ymin_q) : '0;
        res_new.ymax     = found ? BB_COORD_W'(ymax_q) : '0;
        res_new.count    = BB_CNT_W'(cnt_q);
        res_new.found    = found;
        res_new.size_err = (beats_q != FRAME_PIX);
        res_d = res_q;
        rv_d  = rv_q;
        ovf_d = ovf_q;
        if (fin_q) begin
            res_d = res_new;
            rv_d  = 1'b1;
            ovf_d = !xfer && (rv_q || ovf_q);
        end else if (xfer) begin
            rv_d  = 1'b0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q <= '0;
            rv_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            res_q <= res_d;
            rv_q  <= rv_d;
            ovf_q <= ovf_d;
        end
    end

    assign res_valid    = rv_q;
    assign res_overflow = ovf_q;
    assign res_xmin     = COORD_W'(res_q.xmin);
    assign res_xmax     = COORD_W'(res_q.xmax);
    assign res_ymin     = COORD_W'(res_q.ymin);
    assign res_ymax     = COORD_W'(res_q.ymax);
    assign res_count    = CNT_W'(res_q.count);
    assign res_found    = res_q.found;
    assign res_size_err = res_q.size_err;

endmodule

// File: tb/tb_colour_bbox_tracker.sv
// Directed bench for colour_bbox_tracker on a reduced 16x12 frame.
// Vector table for single frames plus hand sequences for corner cases.
module tb_colour_bbox_tracker;

    localparam int W  = 16;
    localparam int H  = 12;
    localparam int CW = 11;
    localparam int NW = 19;

    logic          clk = 1'b0;
    logic          reset;
    logic [23:0]   snk_data;
    logic          snk_valid, snk_startofpacket, snk_endofpacket;
    logic          snk_ready;
    logic [23:0]   src_data;
    logic          src_valid, src_startofpacket, src_endofpacket;
    logic          src_ready;
    logic [23:0]   thr_lo, thr_hi;
    logic          res_valid, res_ready;
    logic [CW-1:0] res_xmin, res_xmax, res_ymin, res_ymax;
    logic [NW-1:0] res_count;
    logic          res_found, res_size_err, res_overflow;

    int total = 0;
    int bad   = 0;

    colour_bbox_tracker #(
        .IMAGE_W(W), .IMAGE_H(H), .COORD_W(CW), .CNT_W(NW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .snk_data          (snk_data),
        .snk_valid         (snk_valid),
        .snk_startofpacket (snk_startofpacket),
        .snk_endofpacket   (snk_endofpacket),
        .snk_ready         (snk_ready),
        .src_data          (src_data),
        .src_valid         (src_valid),
        .src_startofpacket (src_startofpacket),
        .src_endofpacket   (src_endofpacket),
        .src_ready         (src_ready),
        .thr_lo            (thr_lo),
        .thr_hi            (thr_hi),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_xmin          (res_xmin),
        .res_xmax          (res_xmax),
        .res_ymin          (res_ymin),
        .res_ymax          (res_ymax),
        .res_count         (res_count),
        .res_found         (res_found),
        .res_size_err      (res_size_err),
        .res_overflow      (res_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          x0, x1, y0, y1;
        logic [23:0] fg, lo, hi;
        int          nb;
        bit          rnd;
        int          exmin, exmax, eymin, eymax, ecnt;
        bit          efound, eserr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [23:0] d, input logic sop,
                        input logic eop, input bit rnd);
        int   tries = 0;
        logic took  = 1'b0;
        snk_data          = d;
        snk_startofpacket = sop;
        snk_endofpacket   = eop;
        snk_valid         = 1'b1;
        while (!took) begin
            src_ready = (rnd && tries < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
            tries++;
            #1;
            chk("passthru",
                {src_data, src_valid, src_startofpacket,
                 src_endofpacket, snk_ready},
                {d, 1'b1, sop, eop, src_ready});
            @(posedge clk);
            #1;
            took = src_ready;
        end
        snk_valid = 1'b0;
        src_ready = 1'b1;
    endtask

    task automatic send_frame(input logic [3:0] typ, input int nb,
                              input int x0, input int x1,
                              input int y0, input int y1,
                              input logic [23:0] fg, input bit rnd,
                              input int chg_at, input bit term);
        int x, y;
        logic [23:0] d;
        beat({20'h0, typ}, 1'b1, term && nb == 0, rnd);
        for (int i = 0; i < nb; i++) begin
            x = i % W;
            y = i / W;
            if (y > H - 1) y = H - 1;
            d = (x >= x0 && x <= x1 && y >= y0 && y <= y1) ? fg : 24'h0;
            if (i == chg_at) thr_hi = 24'h7F3F3F;
            beat(d, 1'b0, term && i == nb - 1, rnd);
        end
    endtask

    task automatic expect_res(input string nm, input int xmin,
                              input int xmax, input int ymin,
                              input int ymax, input int cnt,
                              input bit fnd, input bit serr,
                              input bit ovf, input bit ack);
        int n = 0;
        repeat (4) tick();
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        chk({nm, ".valid"}, res_valid, 1);
        chk({nm, ".bbox"}, {res_xmin, res_xmax, res_ymin, res_ymax},
            {CW'(xmin), CW'(xmax), CW'(ymin), CW'(ymax)});
        chk({nm, ".count"}, res_count, cnt);
        chk({nm, ".flags"}, {res_found, res_size_err, res_overflow},
            {fnd, serr, ovf});
        if (ack) begin
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            chk({nm, ".ackvalid"}, res_valid, 0);
            chk({nm, ".ackovf"}, res_overflow, 0);
        end
    endtask

    task automatic red_window();
        thr_lo = 24'h800000;
        thr_hi = 24'hFF3F3F;
    endtask

    task automatic red_frame(input int chg_at);
        send_frame(4'h0, W * H, 3, 9, 2, 7, 24'hFF0000, 1'b0, chg_at, 1'b1);
    endtask

    initial begin
        vecs[0] = '{3, 9, 2, 7, 24'hFF0000, 24'h800000, 24'hFF3F3F, 192, 0,
                    3, 9, 2, 7, 42, 1, 0};
        vecs[1] = '{3, 9, 2, 7, 24'h000000, 24'h800000, 24'hFF3F3F, 192, 0,
                    0, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{3, 9, 2, 7, 24'hFF0000, 24'h800000, 24'hFF3F3F, 100, 0,
                    3, 9, 2, 6, 29, 1, 1};
        vecs[3] = '{0, 15, 0, 11, 24'h404040, 24'h404040, 24'h404040, 192, 0,
                    0, 15, 0, 11, 192, 1, 0};
        vecs[4] = '{3, 9, 2, 7, 24'h7F0000, 24'h800000, 24'hFF3F3F, 192, 0,
                    0, 0, 0, 0, 0, 0, 0};
        vecs[5] = '{15, 15, 11, 11, 24'h00FF00, 24'h00F000, 24'h10FFFF, 192, 0,
                    15, 15, 11, 11, 1, 1, 0};
        vecs[6] = '{3, 9, 2, 7, 24'hFF0000, 24'h800000, 24'hFF3F3F, 0, 0,
                    0, 0, 0, 0, 0, 0, 1};
        vecs[7] = '{3, 9, 2, 7, 24'hFF0000, 24'h800000, 24'hFF3F3F, 192, 1,
                    3, 9, 2, 7, 42, 1, 0};

        reset             = 1'b1;
        snk_data          = '0;
        snk_valid         = 1'b0;
        snk_startofpacket = 1'b0;
        snk_endofpacket   = 1'b0;
        src_ready         = 1'b1;
        res_ready         = 1'b0;
        thr_lo            = '0;
        thr_hi            = '0;
        repeat (3) tick();
        chk("rst.valid", {res_valid, res_overflow, res_found, res_size_err}, 0);
        chk("rst.res", {res_xmin, res_xmax, res_ymin, res_ymax, res_count}, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            thr_lo = vecs[i].lo;
            thr_hi = vecs[i].hi;
            send_frame(4'h0, vecs[i].nb, vecs[i].x0, vecs[i].x1, vecs[i].y0,
                       vecs[i].y1, vecs[i].fg, vecs[i].rnd, -1, 1'b1);
            expect_res($sformatf("vec%0d", i), vecs[i].exmin, vecs[i].exmax,
                       vecs[i].eymin, vecs[i].eymax, vecs[i].ecnt,
                       vecs[i].efound, vecs[i].eserr, 1'b0, 1'b1);
        end

        // control packet gives no result; following black frame gives one
        red_window();
        send_frame(4'hF, 10, 3, 9, 2, 7, 24'hFF0000, 1'b0, -1, 1'b1);
        repeat (6) tick();
        chk("ctl.noresult", res_valid, 0);
        send_frame(4'h0, W * H, 0, 0, 0, 0, 24'h000000, 1'b0, -1, 1'b1);
        expect_res("ctl.black", 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // back-to-back frames with no consumer
        red_window();
        red_frame(-1);
        thr_lo = 24'h00F000;
        thr_hi = 24'h10FFFF;
        send_frame(4'h0, W * H, 15, 15, 11, 11, 24'h00FF00, 1'b0, -1, 1'b1);
        expect_res("b2b", 15, 15, 11, 11, 1, 1, 0, 1, 1);

        // SOP mid-frame abandons the partial frame
        red_window();
        send_frame(4'h0, 50, 0, 1, 0, 1, 24'hFF0000, 1'b0, -1, 1'b0);
        red_frame(-1);
        expect_res("abandon", 3, 9, 2, 7, 42, 1, 0, 0, 1);

        // reset mid-frame with an unread result pending
        red_frame(-1);
        repeat (6) tick();
        chk("pend.valid", res_valid, 1);
        send_frame(4'h0, 60, 0, 1, 0, 1, 24'hFF0000, 1'b0, -1, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst.out", {res_valid, res_count, res_xmax}, 0);
        tick();
        tick();
        reset = 1'b0;
        beat(24'hFF0000, 1'b0, 1'b1, 1'b0);
        red_frame(-1);
        expect_res("after_rst", 3, 9, 2, 7, 42, 1, 0, 0, 1);

        // window change mid-frame applies from the next header
        red_window();
        red_frame(100);
        expect_res("thr.old", 3, 9, 2, 7, 42, 1, 0, 0, 1);
        red_frame(-1);
        expect_res("thr.new", 0, 0, 0, 0, 0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
